vec_inst_queue: RTL and testbench

Buffers vector instructions, with their scalar operands, between the scalar processor's issue point and `vec_decode`. Small FIFO with valid/ready handshakes on both sides. Drives `vec_decode`'s `vec_inst`/`rs1_data`/`rs2_data`/`is_vec` inputs. Serialises vector configuration instructions (vsetvli/vsetivli/vsetvl): nothing younger issues until the CSR block acknowledges the new vl/vtype.

---
 rtl/vec_inst_queue_pkg.sv | 29 ++
 rtl/vec_iq_fifo.sv | 53 +++++
 rtl/vec_inst_queue.sv | 117 +++++++++++
 tb/tb_vec_inst_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_inst_queue_pkg.sv
// Shared definitions for the vector instruction queue: opcode fields, entry layout, FSM states.
`ifndef XLEN
`define XLEN 32
`endif

package vec_inst_queue_pkg;

   localparam int IQ_XLEN = `XLEN;

   localparam logic [6:0] V_ARITH = 7'h57;
   localparam logic [2:0] CONF    = 3'b111;

   typedef struct packed {
      logic [IQ_XLEN-1:0] inst;
      logic [IQ_XLEN-1:0] rs1;
      logic [IQ_XLEN-1:0] rs2;
   } vec_iq_entry_t;

   typedef enum logic {
      IQ_RUN,
      IQ_WAIT_CFG
   } vec_iq_state_e;

   // vsetvli/vsetivli/vsetvl all share the OP-V opcode with funct3 = 111
   function automatic logic is_cfg_inst(input logic [14:0] inst_low);
      return (inst_low[6:0] == V_ARITH) && (inst_low[14:12] == CONF);
   endfunction

endpackage

// File: rtl/vec_iq_fifo.sv
// Generic DEPTH x WIDTH circular buffer with head/tail pointers and occupancy count.
// Caller guarantees push only when not full and pop only when not empty.
module vec_iq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 96,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail] <= wr_data;
            tail      <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[head];

endmodule

// File: rtl/vec_inst_queue.sv
// Vector instruction queue between scalar issue and vec_decode; holds younger work behind a
// vector config instruction until cfg_done. Optional same-cycle bypass: define VEC_IQ_BYPASS_EN.
`ifndef XLEN
`define XLEN 32
`endif

module vec_inst_queue
   import vec_inst_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = `XLEN
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_inst,
   input  logic [XLEN-1:0]          in_rs1,
   input  logic [XLEN-1:0]          in_rs2,
   output logic                     is_vec,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          vec_inst,
   output logic [XLEN-1:0]          rs1_data,
   output logic [XLEN-1:0]          rs2_data,
   input  logic                     cfg_done,
   output logic                     cfg_wait,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 3 * XLEN;

   vec_iq_state_e   state;
   vec_iq_state_e   state_next;
   logic [EW-1:0]   head_entry;
   logic [XLEN-1:0] head_inst;
   logic [XLEN-1:0] head_rs1;
   logic [XLEN-1:0] head_rs2;
   logic            bypass;
   logic            push;
   logic            pop;
   logic            cfg_issue;

   assign {head_inst, head_rs1, head_rs2} = head_entry;

`ifdef VEC_IQ_BYPASS_EN
   assign bypass = (count == '0) && (state == IQ_RUN) && in_valid && out_ready;
`else
   assign bypass = 1'b0;
`endif

   // Full is judged on the registered count only, so a same-cycle pop never opens in_ready
   assign in_ready  = (count != (AW+1)'(DEPTH));
   assign push      = in_valid && in_ready && !bypass;
   assign pop       = (state == IQ_RUN) && (count != '0) && out_ready;
   assign cfg_issue = bypass ? is_cfg_inst(in_inst[14:0])
                             : (pop && is_cfg_inst(head_inst[14:0]));

   vec_iq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .push    (push),
      .pop     (pop),
      .wr_data ({in_inst, in_rs1, in_rs2}),
      .rd_data (head_entry),
      .count   (count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IQ_RUN;
      end else begin
         state <= state_next;
      end
   end

   // cfg_done in the same cycle as the config issue is ignored because we are still in RUN
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = IQ_RUN;
      end else begin
         case (state)
            IQ_RUN:      if (cfg_issue) state_next = IQ_WAIT_CFG;
            IQ_WAIT_CFG: if (cfg_done)  state_next = IQ_RUN;
            default:     state_next = IQ_RUN;
         endcase
      end
   end

   always_comb begin
      is_vec   = 1'b0;
      cfg_wait = 1'b0;
      vec_inst = head_inst;
      rs1_data = head_rs1;
      rs2_data = head_rs2;
      case (state)
         IQ_RUN: begin
            is_vec = (count != '0);
            if (bypass) begin
               is_vec   = 1'b1;
               vec_inst = in_inst;
               rs1_data = in_rs1;
               rs2_data = in_rs2;
            end
         end
         IQ_WAIT_CFG: cfg_wait = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_vec_inst_queue.sv
// Scoreboard bench for vec_inst_queue; expectations adapt when VEC_IQ_BYPASS_EN is defined.
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif

module tb_vec_inst_queue;
   import vec_inst_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int XLEN  = `XLEN;
   localparam int CW    = $clog2(DEPTH) + 1;

   localparam logic [XLEN-1:0] VSETVLI = 32'h0D0072D7;
   localparam logic [XLEN-1:0] VADD    = 32'h02008057;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic            cfg_done = 1'b0;
   logic [XLEN-1:0] in_inst = '0;
   logic [XLEN-1:0] in_rs1 = '0;
   logic [XLEN-1:0] in_rs2 = '0;
   logic            in_ready;
   logic            is_vec;
   logic            cfg_wait;
   logic [XLEN-1:0] vec_inst;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [CW-1:0]   count;

   int tests_run = 0;
   int tests_failed = 0;

   vec_iq_entry_t exp_q[$];
   bit            model_wait = 1'b0;

   always #5 clk = ~clk;

   vec_inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inst   (in_inst),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .is_vec    (is_vec),
      .out_ready (out_ready),
      .vec_inst  (vec_inst),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .cfg_done  (cfg_done),
      .cfg_wait  (cfg_wait),
      .count     (count)
   );

   task automatic checkOutput(input string tag, input logic [XLEN-1:0] actual,
                              input logic [XLEN-1:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   function automatic bit is_cfg_tb(input logic [XLEN-1:0] inst);
      return (inst[6:0] == 7'h57) && (inst[14:12] == 3'b111);
   endfunction

   // Drive one cycle of inputs, check against the scoreboard at the falling edge, then advance.
   task automatic applyStimulus(input logic v, input logic [XLEN-1:0] inst,
                                input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                input logic rdy, input logic cdone, input logic fl);
      int            occ;
      bit            byp;
      bit            old_wait;
      bit            exp_isvec;
      bit            exp_ready;
      bit            popping;
      bit            pushing;
      vec_iq_entry_t head;
      vec_iq_entry_t incoming;
      in_valid  = v;
      in_inst   = inst;
      in_rs1    = rs1;
      in_rs2    = rs2;
      out_ready = rdy;
      cfg_done  = cdone;
      flush     = fl;
      @(negedge clk);
      occ      = exp_q.size();
      old_wait = model_wait;
      byp      = 1'b0;
`ifdef VEC_IQ_BYPASS_EN
      byp = (occ == 0) && !old_wait && v && rdy;
`endif
      exp_isvec = !old_wait && ((occ != 0) || byp);
      exp_ready = (occ != DEPTH);
      incoming  = '{inst: inst, rs1: rs1, rs2: rs2};
      head      = byp ? incoming : ((occ != 0) ? exp_q[0] : incoming);
      checkOutput("is_vec", XLEN'(is_vec), XLEN'(exp_isvec));
      checkOutput("in_ready", XLEN'(in_ready), XLEN'(exp_ready));
      checkOutput("cfg_wait", XLEN'(cfg_wait), XLEN'(old_wait));
      checkOutput("count", XLEN'(count), XLEN'(occ));
      if (exp_isvec) begin
         checkOutput("vec_inst", vec_inst, head.inst);
         checkOutput("rs1_data", rs1_data, head.rs1);
         checkOutput("rs2_data", rs2_data, head.rs2);
      end
      popping = exp_isvec && rdy;
      pushing = v && exp_ready && !byp;
      if (fl) begin
         exp_q.delete();
         model_wait = 1'b0;
      end else begin
         if (popping && !byp) void'(exp_q.pop_front());
         if (pushing) exp_q.push_back(incoming);
         if (popping && is_cfg_tb(head.inst)) model_wait = 1'b1;
         else if (old_wait && cdone) model_wait = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, rdy, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset values while reset is held
      #2;
      checkOutput("rst_count", XLEN'(count), '0);
      checkOutput("rst_is_vec", XLEN'(is_vec), '0);
      checkOutput("rst_in_ready", XLEN'(in_ready), 1);
      checkOutput("rst_cfg_wait", XLEN'(cfg_wait), '0);
      checkOutput("rst_vec_inst", vec_inst, '0);
      #10 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill with out_ready low, refuse a fifth push, then drain in order
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, VADD | XLEN'(i << 7), XLEN'(32'h1000 + i), XLEN'(32'h2000 + i),
                       1'b0, 1'b0, 1'b0);
      checkOutput("full_count", XLEN'(count), 4);
      checkOutput("full_in_ready", XLEN'(in_ready), '0);
      applyStimulus(1'b1, VADD | 32'hF00, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b0);
      idle(1'b1, 5);
      checkOutput("drained_count", XLEN'(count), '0);

      // Wrap-around with alternating out_ready
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, 32'h02000057 | XLEN'(i << 20), XLEN'(32'h3000 + i),
                       XLEN'(32'h4000 + i), logic'(i % 2), 1'b0, 1'b0);
      idle(1'b1, 6);

      // Config serialisation: vsetvli then vadd; vadd waits for cfg_done
      applyStimulus(1'b1, VSETVLI, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, VADD, 32'h33, 32'h44, 1'b1, 1'b0, 1'b0);
      idle(1'b1, 2);
      checkOutput("cfg_wait_held", XLEN'(cfg_wait), 1);
      checkOutput("cfg_is_vec_blocked", XLEN'(is_vec), '0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
      checkOutput("cfg_released", XLEN'(is_vec), 1);
      checkOutput("cfg_released_inst", vec_inst, VADD);
      idle(1'b1, 2);

      // Flush with count=3 and a same-cycle push
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, VADD | XLEN'(i << 8), XLEN'(32'h50 + i), XLEN'(32'h60 + i),
                       1'b0, 1'b0, 1'b0);
      checkOutput("pre_flush_count", XLEN'(count), 3);
      applyStimulus(1'b1, 32'h0AAA0057, 32'h77, 32'h88, 1'b0, 1'b0, 1'b1);
      checkOutput("flush_count", XLEN'(count), '0);
      checkOutput("flush_is_vec", XLEN'(is_vec), '0);
      idle(1'b0, 1);

      // Flush during WAIT_CFG returns to RUN
      applyStimulus(1'b1, VSETVLI, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
      idle(1'b1, 1);
      checkOutput("wait_before_flush", XLEN'(cfg_wait), 1);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
      checkOutput("wait_after_flush", XLEN'(cfg_wait), '0);
      idle(1'b0, 1);

      // Asynchronous reset between edges with two entries queued
      for (int i = 0; i < 2; i++)
         applyStimulus(1'b1, VADD | XLEN'(i << 9), XLEN'(32'hA0 + i), XLEN'(32'hB0 + i),
                       1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checkOutput("arst_count", XLEN'(count), '0);
      checkOutput("arst_is_vec", XLEN'(is_vec), '0);
      checkOutput("arst_in_ready", XLEN'(in_ready), 1);
      checkOutput("arst_vec_inst", vec_inst, '0);
      checkOutput("arst_rs1", rs1_data, '0);
      exp_q.delete();
      model_wait = 1'b0;
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Same-cycle visibility on an empty queue depends on the bypass build option
      in_valid  = 1'b1;
      in_inst   = VADD | 32'h100;
      in_rs1    = 32'hC1;
      in_rs2    = 32'hC2;
      out_ready = 1'b1;
      #1;
`ifdef VEC_IQ_BYPASS_EN
      checkOutput("bypass_is_vec", XLEN'(is_vec), 1);
      checkOutput("bypass_inst", vec_inst, VADD | 32'h100);
`else
      checkOutput("nobypass_is_vec", XLEN'(is_vec), '0);
`endif
      checkOutput("bypass_count", XLEN'(count), '0);
      applyStimulus(1'b1, VADD | 32'h100, 32'hC1, 32'hC2, 1'b1, 1'b0, 1'b0);
      idle(1'b1, 3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
